// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divide/remainder unit.
package div_unit_pkg;

  localparam int unsigned DIV_OP_WIDTH = 2;

  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem,quot} left, trial-subtract the divisor.
module div_unit_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // Shifted partial remainder carries one extra bit so large unsigned divisors compare correctly.
  always_comb begin
    w_rem_sh = {i_rem, i_quot[XLEN-1]};
    w_ge     = (w_rem_sh >= {1'b0, i_divisor});
    w_diff   = w_rem_sh[XLEN-1:0] - i_divisor;
    o_rem    = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
    o_quot   = {i_quot[XLEN-2:0], w_ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV64M DIV/DIVU/REM/REMU (+W) unit with valid/ready request and response.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  input  logic [DIV_OP_WIDTH-1:0] op,
  input  logic                    word,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         res,
  output logic                    busy
);

  localparam int unsigned WLEN = 32;

  div_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rem, r_quot, r_divisor;
  logic            r_neg_q, r_neg_r, r_word, r_sel_rem;

  logic            w_accept, w_signed, w_sel_rem, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min_neg;
  logic [XLEN-1:0] w_step_rem, w_step_quot;
  logic [XLEN-1:0] w_q_fix, w_r_fix, w_sel, w_res;

  assign in_ready = (r_state == DIV_ST_IDLE) && !flush;
  assign busy     = (r_state != DIV_ST_IDLE);
  assign w_accept = in_valid && in_ready;

  // Operand extension, magnitudes and special-case detection at accept time.
  always_comb begin
    w_signed  = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    w_sel_rem = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    if (word) begin
      w_a_ext   = {{(XLEN-WLEN){w_signed & a[WLEN-1]}}, a[WLEN-1:0]};
      w_b_ext   = {{(XLEN-WLEN){w_signed & b[WLEN-1]}}, b[WLEN-1:0]};
      w_min_neg = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
    end else begin
      w_a_ext   = a;
      w_b_ext   = b;
      w_min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    w_a_neg = w_signed & w_a_ext[XLEN-1];
    w_b_neg = w_signed & w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_div0  = (w_b_ext == '0);
    w_ovf   = w_signed && (w_a_ext == w_min_neg) && (&w_b_ext);
  end

  div_unit_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  // Sign fixup, quotient/remainder select and W-variant sign extension.
  always_comb begin
    w_q_fix = r_neg_q ? -r_quot : r_quot;
    w_r_fix = r_neg_r ? -r_rem : r_rem;
    w_sel   = r_sel_rem ? w_r_fix : w_q_fix;
    w_res   = r_word ? {{(XLEN-WLEN){w_sel[WLEN-1]}}, w_sel[WLEN-1:0]} : w_sel;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_ST_IDLE: if (w_accept) w_state_nxt = (w_div0 || w_ovf) ? DIV_ST_DONE : DIV_ST_CALC;
      DIV_ST_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = DIV_ST_DONE;
      DIV_ST_DONE: if (out_valid && out_ready) w_state_nxt = DIV_ST_IDLE;
      default:     w_state_nxt = DIV_ST_IDLE;
    endcase
    if (flush) w_state_nxt = DIV_ST_IDLE;
  end

  // Operand capture on accept, one restoring iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_word    <= 1'b0;
      r_sel_rem <= 1'b0;
    end else if (w_accept) begin
      r_divisor <= w_b_mag;
      r_word    <= word;
      r_sel_rem <= w_sel_rem;
      r_cnt     <= word ? CNT_W'(WLEN) : CNT_W'(XLEN);
      if (w_div0) begin
        r_quot  <= '1;
        r_rem   <= w_a_ext;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_quot  <= w_a_ext;
        r_rem   <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        // W dividends sit in the top half so N=32 shifts feed all their bits into rem.
        r_quot  <= word ? (w_a_mag << WLEN) : w_a_mag;
        r_rem   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end else if (r_state == DIV_ST_CALC) begin
      r_rem  <= w_step_rem;
      r_quot <= w_step_quot;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  // Result register: loaded once on DONE entry, held until the response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (r_state == DIV_ST_DONE && !out_valid) begin
      res       <= w_res;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, handshake corners, random vs reference model.
module tb_div_unit;

  logic        clk, rst, in_valid, in_ready, word, flush, out_valid, out_ready, busy;
  logic [63:0] a, b, res;
  logic [1:0]  op;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       name;
    logic [63:0] va;
    logic [63:0] vb;
    logic [1:0]  vop;
    logic        vword;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  div_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .word(word), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain arithmetic.
  function automatic logic [63:0] model_res(input logic [63:0] ma, input logic [63:0] mb,
                                            input logic [1:0] mop, input logic mword);
    longint      sa, sb, smin;
    logic [63:0] ua, ub, q, r, sel;
    logic [31:0] a32, b32;
    a32 = ma[31:0];
    b32 = mb[31:0];
    if (mword) begin
      sa = longint'($signed(a32)); sb = longint'($signed(b32));
      ua = {32'b0, a32};           ub = {32'b0, b32};
      smin = -64'sd2147483648;
    end else begin
      sa = $signed(ma); sb = $signed(mb);
      ua = ma;          ub = mb;
      smin = longint'(64'h8000000000000000);
    end
    if (mop[0] == 1'b0) begin
      if (sb == 0) begin q = '1; r = 64'(sa); end
      else if (sa == smin && sb == -1) begin q = 64'(sa); r = '0; end
      else begin q = 64'(sa / sb); r = 64'(sa % sb); end
    end else begin
      if (ub == 0) begin q = '1; r = ua; end
      else begin q = ua / ub; r = ua % ub; end
    end
    sel = mop[1] ? r : q;
    if (mword) sel = {{32{sel[31]}}, sel[31:0]};
    return sel;
  endfunction

  function automatic int model_lat(input logic [63:0] ma, input logic [63:0] mb,
                                   input logic [1:0] mop, input logic mword);
    logic zero, ovf;
    if (mword) begin
      zero = (mb[31:0] == 32'h0);
      ovf  = !mop[0] && (ma[31:0] == 32'h80000000) && (mb[31:0] == 32'hFFFFFFFF);
      return (zero || ovf) ? 1 : 33;
    end
    zero = (mb == 64'h0);
    ovf  = !mop[0] && (ma == 64'h8000000000000000) && (mb == '1);
    return (zero || ovf) ? 1 : 65;
  endfunction

  // Present a request for one edge (unit assumed idle), then scramble operands.
  task automatic send(input logic [63:0] ta, input logic [63:0] tb_, input logic [1:0] top, input logic tw);
    @(negedge clk);
    a = ta; b = tb_; op = top; word = tw; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = 2'($urandom_range(0, 3));
    word = 1'($urandom_range(0, 1));
  endtask

  // Count edges after accept until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string name, input logic [63:0] ta, input logic [63:0] tb_,
                     input logic [1:0] top, input logic tw, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    send(ta, tb_, top, tw);
    wait_valid(lat);
    check({name, " res"}, res, exp_res);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic [63:0] ra, rb, held;
    logic [1:0]  rop;
    logic        rw;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00; word = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset res", res, 64'h0);
    check("reset in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"DIVU 100/7",   64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 65});
    vecs.push_back('{"REMU 100/7",   64'd100, 64'd7, 2'b11, 1'b0, 64'd2, 65});
    vecs.push_back('{"DIV -7/2",     64'hFFFFFFFFFFFFFFF9, 64'd2, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFD, 65});
    vecs.push_back('{"REM -7/2",     64'hFFFFFFFFFFFFFFF9, 64'd2, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 65});
    vecs.push_back('{"DIVU 5/0",     64'd5, 64'd0, 2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1});
    vecs.push_back('{"REMU 5/0",     64'd5, 64'd0, 2'b11, 1'b0, 64'd5, 1});
    vecs.push_back('{"DIVUW 5/0",    64'd5, 64'd0, 2'b01, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1});
    vecs.push_back('{"REM -7/0",     64'hFFFFFFFFFFFFFFF9, 64'd0, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFF9, 1});
    vecs.push_back('{"DIV ovf",      64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b0, 64'h8000000000000000, 1});
    vecs.push_back('{"REM ovf",      64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b10, 1'b0, 64'h0, 1});
    vecs.push_back('{"DIVW ovf",     64'h0000000080000000, 64'h00000000FFFFFFFF, 2'b00, 1'b1, 64'hFFFFFFFF80000000, 1});
    vecs.push_back('{"DIVUW big/1",  64'h12345678FFFFFFFE, 64'd1, 2'b01, 1'b1, 64'hFFFFFFFFFFFFFFFE, 33});
    vecs.push_back('{"REMW -7/2",    64'hFFFFFFFFFFFFFFF9, 64'd2, 2'b10, 1'b1, 64'hFFFFFFFFFFFFFFFF, 33});
    vecs.push_back('{"DIVU max/max", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 2'b01, 1'b0, 64'd1, 65});
    vecs.push_back('{"REMU 2^63+5/2^63", 64'h8000000000000005, 64'h8000000000000000, 2'b11, 1'b0, 64'd5, 65});

    foreach (vecs[i])
      run(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].vword,
          vecs[i].exp_res, vecs[i].exp_lat);

    // Output hold while the consumer stalls.
    out_ready = 1'b0;
    send(64'd100, 64'd7, 2'b01, 1'b0);
    wait_valid(lat);
    check("hold first res", res, 64'd14);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold out_valid", 64'(out_valid), 64'(1));
      check("hold res", res, 64'd14);
    end
    check("hold busy", 64'(busy), 64'(1));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", 64'(out_valid), 64'(0));
    check("release busy", 64'(busy), 64'(0));

    // Flush at CALC cycle 10; res keeps its last value.
    send(64'hDEADBEEFCAFEF00D, 64'd3, 2'b01, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'(0));
    check("flush out_valid", 64'(out_valid), 64'(0));
    check("flush res kept", res, 64'd14);
    run("DIVU after flush", 64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 65);

    // Flush beats a simultaneous request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; a = 64'd9; b = 64'd3; op = 2'b01; word = 1'b0;
    #1;
    check("flush in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush vs accept busy", 64'(busy), 64'(0));

    // Asynchronous reset mid-CALC.
    send(64'd1000, 64'd9, 2'b00, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst mid-CALC busy", 64'(busy), 64'(0));
    check("rst mid-CALC out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while a result is held: out_valid drops without an edge.
    out_ready = 1'b0;
    send(64'd5, 64'd0, 2'b01, 1'b0);
    wait_valid(lat);
    check("pre-rst out_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst in DONE out_valid", 64'(out_valid), 64'(0));
    check("rst in DONE busy", 64'(busy), 64'(0));
    check("rst in DONE res", res, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // Randomised operations against the reference model.
    for (int n = 0; n < 200; n++) begin
      rop = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: rb = {$urandom, 32'h0} & (rw ? 64'hFFFFFFFF00000000 : 64'h0);
        1: rb = 64'($urandom_range(1, 20));
        2: rb = '1;
        3: rb = {$urandom, $urandom};
        4: rb = {32'h0, $urandom};
        default: rb = -64'($urandom_range(1, 20));
      endcase
      if ($urandom_range(0, 7) == 0) ra = rw ? {$urandom, 32'h80000000} : 64'h8000000000000000;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(8, 62);
      run("random", ra, rb, rop, rw, model_res(ra, rb, rop, rw), model_lat(ra, rb, rop, rw));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
